timer_compare_unit: RTL and testbench
=====================================

TIMER_COMPARE_UNIT -- requirements
Module: timer_compare_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, counter/compare width.
REQ-002 SHALL have parameter PRE_W, default 8, prescaler width.
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port en  input  1  global count enable; when 0, prescaler and counter hold.
REQ-006 SHALL have port wr_en  input  1  register write strobe.
REQ-007 SHALL have port addr  input  3  register select for read and write.
REQ-008 SHALL have port wr_data  input  WIDTH  write data.
REQ-009 SHALL have port rd_data  output  WIDTH  combinational read of the register at addr.
REQ-010 SHALL have port irq  output  1  level interrupt = STATUS.pend AND CTRL.ie.

Function
REQ-011 SHALL map registers: 0 CTRL{ie[2],periodic[1],run[0]}, 1 PRESC[PRE_W-1:0], 2 CMP, 3 COUNT, 4 STATUS{pend[0]}; addr 5-7 read 0, writes ignored; unused bits read 0.
REQ-012 SHALL implement states IDLE (run=0), RUN (run=1), DONE (one-shot expired); run bit reads 1 only in RUN.
REQ-013 SHALL enter RUN from IDLE or DONE on write of CTRL with run=1; COUNT value is kept, prescaler cleared.
REQ-014 SHALL enter IDLE from any state on write of CTRL with run=0; COUNT holds, prescaler cleared.
REQ-015 SHALL, in RUN with en=1, increment the prescaler each cycle; tick occurs on the cycle prescaler==PRESC, prescaler then returns to 0 (PRESC=0: tick every en cycle).
REQ-016 SHALL, on a tick with COUNT!=CMP, set COUNT <= COUNT+1 modulo 2^WIDTH (max wraps to 0, no flag).
REQ-017 SHALL, on a tick with COUNT==CMP, set pend on the next edge (irq visible one cycle after the tick cycle).
REQ-018 SHALL, on match with periodic=1, load COUNT <= 0 and stay RUN; period = (CMP+1)*(PRESC+1) en cycles.
REQ-019 SHALL, on match with periodic=0, hold COUNT at CMP, clear run, enter DONE.
REQ-020 SHALL give a COUNT write priority over tick increment/reload in the same cycle; the write also clears the prescaler.
REQ-021 SHALL treat STATUS as write-1-to-clear; a match in the same cycle as a clear leaves pend=1.
REQ-022 SHALL not clear pend on state change; pend is sticky until W1C or reset.
REQ-023 SHALL apply CMP/PRESC writes from the next cycle; a CMP written below a running COUNT is reached only after wrap-around.
REQ-024 SHALL never tick in IDLE or DONE, or when en=0 (prescaler frozen, not cleared).

Reset
REQ-025 SHALL, when rst=1 at a clock edge, set CTRL=0, PRESC=0, CMP=all-ones, COUNT=0, pend=0, prescaler=0, state IDLE; irq=0 the following cycle.
REQ-026 SHALL let rst override any simultaneous write or tick, including mid-RUN.

Verification
REQ-027 Periodic: CMP=3, PRESC=0, CTRL=0b111, en=1 -> COUNT 0,1,2,3,0...; pend set each 4 cycles; irq high after first match, stays until STATUS write 1.
REQ-028 Prescale one-shot: CMP=2, PRESC=1, CTRL=0b101 -> COUNT steps every 2 cycles; pend after 6 en cycles; COUNT holds 2, CTRL reads 0b100, state DONE.
REQ-029 Wrap: COUNT=0xFFFF_FFFE, CMP=1, periodic run -> COUNT FFFF_FFFF,0,1 then match; no pend before COUNT==1.
REQ-030 Collisions: COUNT write 0x10 on a tick cycle -> COUNT=0x10; STATUS W1C on match cycle -> pend=1.
REQ-031 en gating: drop en for 5 cycles mid-prescale (PRESC=3) -> prescaler and COUNT frozen, resume from same phase.
REQ-032 Reset mid-RUN with pend=1 -> all registers at REQ-025 values, irq=0, no tick next cycle.

Source files
------------

// File: rtl/timer_compare_unit.sv
// -----------------------------------------------------------------------------
// timer_compare_unit
//
// Prescaled up-counter with a compare register, periodic or one-shot mode and
// a sticky pending flag that drives a level interrupt.
//
// Register map (addr):
//   0 CTRL   {ie[2], periodic[1], run[0]}   run reads 1 only while running
//   1 PRESC  [PRE_W-1:0]                     tick every PRESC+1 enabled cycles
//   2 CMP    [WIDTH-1:0]                     match value
//   3 COUNT  [WIDTH-1:0]                     current count
//   4 STATUS {pend[0]}                       write 1 to clear
//   5-7      read 0, writes ignored
//
// Ports:
//   clk      single clock, all state updates on the rising edge
//   rst      synchronous active-high reset
//   en       global count enable; prescaler and counter hold while low
//   wr_en    register write strobe
//   addr     register select for read and write
//   wr_data  write data
//   rd_data  combinational read of the register selected by addr
//   irq      level interrupt, pend AND ie
//   state    current FSM state (0 IDLE, 1 RUN, 2 DONE) for debug/observation
//
// Handshake: there is none beyond the strobe; a write with wr_en=1 takes
// effect at the next rising edge, and rd_data reflects addr in the same cycle.
// -----------------------------------------------------------------------------
module timer_compare_unit #(
    parameter int WIDTH = 32,
    parameter int PRE_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             wr_en,
    input  logic [2:0]       addr,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] rd_data,
    output logic             irq,
    output logic [1:0]       state
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic               ie_q;
    logic               periodic_q;
    logic [PRE_W-1:0]   presc_q;
    logic [WIDTH-1:0]   cmp_q;
    logic [WIDTH-1:0]   count_q;
    logic               pend_q;
    logic [PRE_W-1:0]   pcnt_q;

    logic               wr_ctrl, wr_presc, wr_cmp, wr_count, wr_status;
    logic               running, tick, match;

    assign wr_ctrl   = wr_en && (addr == 3'd0);
    assign wr_presc  = wr_en && (addr == 3'd1);
    assign wr_cmp    = wr_en && (addr == 3'd2);
    assign wr_count  = wr_en && (addr == 3'd3);
    assign wr_status = wr_en && (addr == 3'd4);

    assign running = (state_q == ST_RUN);
    // '>=' rather than '==' so that lowering PRESC below the live prescaler
    // value ticks on the next enabled cycle instead of waiting for a wrap.
    assign tick    = running && en && (pcnt_q >= presc_q);
    assign match   = tick && (count_q == cmp_q);

    // FSM next-state: a CTRL write always decides the state; otherwise a
    // one-shot match retires the timer into DONE.
    always_comb begin
        state_d = state_q;
        if (wr_ctrl) begin
            state_d = wr_data[0] ? ST_RUN : ST_IDLE;
        end else if (match && !periodic_q) begin
            state_d = ST_DONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Configuration registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            ie_q       <= 1'b0;
            periodic_q <= 1'b0;
            presc_q    <= '0;
            cmp_q      <= '1;
        end else begin
            if (wr_ctrl) begin
                ie_q       <= wr_data[2];
                periodic_q <= wr_data[1];
            end
            if (wr_presc) begin
                presc_q <= wr_data[PRE_W-1:0];
            end
            if (wr_cmp) begin
                cmp_q <= wr_data;
            end
        end
    end

    // Prescaler: cleared on any CTRL or COUNT write so a (re)started count
    // always begins a full prescale period; frozen when not running or en=0.
    always_ff @(posedge clk) begin
        if (rst) begin
            pcnt_q <= '0;
        end else if (wr_ctrl || wr_count) begin
            pcnt_q <= '0;
        end else if (running && en) begin
            pcnt_q <= tick ? '0 : pcnt_q + PRE_W'(1);
        end
    end

    // Counter: a software write beats the tick-driven update.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else if (wr_count) begin
            count_q <= wr_data;
        end else if (tick) begin
            if (match) begin
                count_q <= periodic_q ? '0 : count_q;
            end else begin
                count_q <= count_q + WIDTH'(1);
            end
        end
    end

    // Pending flag: a match wins over a simultaneous write-1-to-clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_q <= 1'b0;
        end else if (match) begin
            pend_q <= 1'b1;
        end else if (wr_status && wr_data[0]) begin
            pend_q <= 1'b0;
        end
    end

    always_comb begin
        rd_data = '0;
        case (addr)
            3'd0:    rd_data[2:0]       = {ie_q, periodic_q, running};
            3'd1:    rd_data[PRE_W-1:0] = presc_q;
            3'd2:    rd_data            = cmp_q;
            3'd3:    rd_data            = count_q;
            3'd4:    rd_data[0]         = pend_q;
            default: rd_data            = '0;
        endcase
    end

    assign irq   = pend_q && ie_q;
    assign state = state_q;

endmodule

// File: tb/tb_timer_compare_unit.sv
// -----------------------------------------------------------------------------
// tb_timer_compare_unit
//
// Directed bench: the stimulus process issues register writes and enable
// windows, and for every observation pushes the hand-computed expected value
// into exp_q while raising rd_strobe. The monitor process pops and compares on
// the falling edge whenever rd_strobe is high.
// Observation selectors: 0-7 register at addr, 8 irq, 9 FSM state.
// -----------------------------------------------------------------------------
module tb_timer_compare_unit;

    localparam int W = 32;

    logic         clk;
    logic         rst;
    logic         en;
    logic         wr_en;
    logic [2:0]   addr;
    logic [W-1:0] wr_data;
    logic [W-1:0] rd_data;
    logic         irq;
    logic [1:0]   fsm_state;

    logic         rd_strobe;
    logic [W-1:0] exp_q[$];
    int           sel_q[$];
    string        name_q[$];
    int           checks;
    int           errors;

    timer_compare_unit #(.WIDTH(W), .PRE_W(8)) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .wr_en   (wr_en),
        .addr    (addr),
        .wr_data (wr_data),
        .rd_data (rd_data),
        .irq     (irq),
        .state   (fsm_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- driver tasks ----------------
    // All tasks start and end at 1 time unit after a rising edge.
    task automatic wr(input logic [2:0] a, input logic [W-1:0] d, input logic e);
        addr    = a;
        wr_data = d;
        wr_en   = 1'b1;
        en      = e;
        @(posedge clk); #1;
        wr_en   = 1'b0;
        en      = 1'b0;
    endtask

    task automatic run(input int n);
        en = 1'b1;
        repeat (n) @(posedge clk);
        #1;
        en = 1'b0;
    endtask

    task automatic chk(input int sel, input logic [W-1:0] v, input string nm);
        if (sel < 8) addr = 3'(sel);
        exp_q.push_back(v);
        sel_q.push_back(sel);
        name_q.push_back(nm);
        rd_strobe = 1'b1;
        @(posedge clk); #1;
        rd_strobe = 1'b0;
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        if (rd_strobe) begin
            logic [W-1:0] act;
            logic [W-1:0] e;
            int           s;
            string        nm;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL scoreboard_empty: no expected entry for strobe");
            end else begin
                e  = exp_q.pop_front();
                s  = sel_q.pop_front();
                nm = name_q.pop_front();
                if (s == 8)      act = {{(W-1){1'b0}}, irq};
                else if (s == 9) act = {{(W-2){1'b0}}, fsm_state};
                else             act = rd_data;
                if (act !== e) begin
                    errors++;
                    $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, e);
                end
            end
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // ---------------- stimulus ----------------
    initial begin
        checks    = 0;
        errors    = 0;
        rst       = 1'b1;
        en        = 1'b0;
        wr_en     = 1'b0;
        addr      = 3'd0;
        wr_data   = '0;
        rd_strobe = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset values
        chk(0, 32'h0000_0000, "rst_ctrl");
        chk(1, 32'h0000_0000, "rst_presc");
        chk(2, 32'hFFFF_FFFF, "rst_cmp");
        chk(3, 32'h0000_0000, "rst_count");
        chk(4, 32'h0000_0000, "rst_status");
        chk(8, 32'h0, "rst_irq");
        chk(9, 32'h0, "rst_state");

        // Unused bits and unmapped addresses
        wr(3'd0, 32'hFFFF_FFF8, 1'b0);
        chk(0, 32'h0000_0000, "ctrl_unused_bits");
        wr(3'd1, 32'hFFFF_FF05, 1'b0);
        chk(1, 32'h0000_0005, "presc_masked");
        wr(3'd5, 32'hDEAD_BEEF, 1'b0);
        chk(5, 32'h0000_0000, "addr5_reads0");

        // Periodic: CMP=3, PRESC=0
        wr(3'd1, 32'd0, 1'b0);
        wr(3'd2, 32'd3, 1'b0);
        wr(3'd0, 32'h7, 1'b0);
        run(3);
        chk(3, 32'd3, "per_count3");
        chk(4, 32'd0, "per_no_pend_yet");
        run(1);
        chk(3, 32'd0, "per_reload");
        chk(4, 32'd1, "per_pend");
        chk(8, 32'h1, "per_irq");
        chk(0, 32'h7, "per_ctrl");
        run(5);
        chk(3, 32'd1, "per_count_after9");
        chk(4, 32'd1, "per_pend_sticky");
        wr(3'd4, 32'd1, 1'b0);
        chk(4, 32'd0, "per_w1c");
        chk(8, 32'h0, "per_irq_clear");

        // Prescaled one-shot: CMP=2, PRESC=1
        wr(3'd0, 32'h0, 1'b0);
        wr(3'd3, 32'd0, 1'b0);
        wr(3'd2, 32'd2, 1'b0);
        wr(3'd1, 32'd1, 1'b0);
        wr(3'd0, 32'h5, 1'b0);
        run(5);
        chk(3, 32'd2, "os_count_at5");
        chk(4, 32'd0, "os_no_pend_at5");
        chk(9, 32'h1, "os_state_run");
        run(1);
        chk(4, 32'd1, "os_pend_at6");
        chk(9, 32'h2, "os_state_done");
        chk(0, 32'h4, "os_ctrl_run_clear");
        chk(3, 32'd2, "os_count_hold");
        chk(8, 32'h1, "os_irq");
        run(4);
        chk(3, 32'd2, "os_no_tick_done");
        wr(3'd4, 32'd1, 1'b0);

        // Wrap-around
        wr(3'd0, 32'h2, 1'b0);
        wr(3'd3, 32'hFFFF_FFFE, 1'b0);
        wr(3'd2, 32'd1, 1'b0);
        wr(3'd1, 32'd0, 1'b0);
        wr(3'd0, 32'h3, 1'b0);
        run(1);
        chk(3, 32'hFFFF_FFFF, "wrap_max");
        run(2);
        chk(3, 32'd1, "wrap_count1");
        chk(4, 32'd0, "wrap_no_pend");
        run(1);
        chk(3, 32'd0, "wrap_reload");
        chk(4, 32'd1, "wrap_pend");
        chk(8, 32'h0, "wrap_irq_masked");
        wr(3'd4, 32'd1, 1'b0);
        chk(4, 32'd0, "wrap_w1c");

        // Collisions
        wr(3'd3, 32'h10, 1'b1);
        chk(3, 32'h10, "col_count_write_wins");
        wr(3'd3, 32'd1, 1'b0);
        run(1);
        chk(4, 32'd1, "col_pend_set");
        wr(3'd3, 32'd1, 1'b0);
        wr(3'd4, 32'd1, 1'b1);
        chk(4, 32'd1, "col_match_beats_w1c");
        chk(3, 32'd0, "col_count_reload");
        wr(3'd4, 32'd1, 1'b0);
        chk(4, 32'd0, "col_w1c_alone");

        // en gating mid-prescale: PRESC=3
        wr(3'd2, 32'd100, 1'b0);
        wr(3'd1, 32'd3, 1'b0);
        wr(3'd3, 32'd0, 1'b0);
        wr(3'd0, 32'h3, 1'b0);
        run(6);
        repeat (5) @(posedge clk);
        #1;
        chk(3, 32'd1, "gate_frozen");
        run(1);
        chk(3, 32'd1, "gate_phase_kept");
        run(1);
        chk(3, 32'd2, "gate_resume_tick");

        // Reset mid-RUN with pend=1
        wr(3'd1, 32'd0, 1'b0);
        wr(3'd2, 32'd2, 1'b0);
        wr(3'd0, 32'h7, 1'b0);
        run(1);
        chk(8, 32'h1, "pre_rst_irq");
        chk(9, 32'h1, "pre_rst_state");
        addr    = 3'd3;
        wr_data = 32'h55;
        wr_en   = 1'b1;
        en      = 1'b1;
        rst     = 1'b1;
        @(posedge clk); #1;
        rst     = 1'b0;
        wr_en   = 1'b0;
        run(1);
        chk(0, 32'h0000_0000, "mrst_ctrl");
        chk(1, 32'h0000_0000, "mrst_presc");
        chk(2, 32'hFFFF_FFFF, "mrst_cmp");
        chk(3, 32'h0000_0000, "mrst_count_no_tick");
        chk(4, 32'h0000_0000, "mrst_status");
        chk(8, 32'h0, "mrst_irq");
        chk(9, 32'h0, "mrst_state");

        @(posedge clk); #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
